// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR tap sequencer.
package fir_pkg;

    localparam int unsigned NTAPS   = 5;
    localparam int unsigned LATENCY = 5;
    localparam int unsigned XW      = 16;
    localparam int unsigned YW      = 32;
    localparam int unsigned CW      = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        SWAP  = 2'd2
    } state_t;

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient registers: shadow is written by the config port,
// active drives the datapath and is only replaced by a swap.
module fir_coef_bank
    import fir_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr,
    input  logic [2:0]          addr,
    input  logic [CW-1:0]       wdata,
    input  logic                swap,
    output logic [NTAPS*CW-1:0] coef,
    output logic                err
);

    localparam logic [2:0] NTAPS_ADDR = 3'(NTAPS);

    logic [CW-1:0] shadow_q [NTAPS];
    logic [CW-1:0] active_q [NTAPS];
    logic          err_q;
    logic          wr_ok;

    // Out-of-range writes are dropped and only flag the error.
    assign wr_ok = wr & (addr < NTAPS_ADDR);
    assign err   = err_q;

    // Swap copies the pre-write shadow, so a same-cycle write lands after the copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(NTAPS); k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (swap) begin
                for (int k = 0; k < int'(NTAPS); k++) begin
                    active_q[k] <= shadow_q[k];
                end
            end
            if (wr_ok) begin
                shadow_q[addr] <= wdata;
            end
            if (wr && !wr_ok) begin
                err_q <= 1'b1;
            end
        end
    end

    // Flatten active taps; tap k occupies bits [k*CW +: CW].
    always_comb begin
        coef = '0;
        for (int k = 0; k < int'(NTAPS); k++) begin
            coef[k*CW +: CW] = active_q[k];
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Sequencer for the five-tap FIR datapath: turns the sample handshake into the
// datapath advance strobe, tracks which pipeline slots hold real samples, and
// drains the pipe before flush completion or a coefficient swap.
module fir_tap_sequencer
    import fir_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [XW-1:0]       s_data,
    output logic [XW-1:0]       dp_x,
    output logic                dp_ena,
    input  logic [YW-1:0]       dp_y,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [YW-1:0]       m_data,
    output logic [NTAPS*CW-1:0] coef,
    input  logic                cfg_wr,
    input  logic [2:0]          cfg_addr,
    input  logic [CW-1:0]       cfg_data,
    input  logic                cfg_commit,
    output logic                cfg_busy,
    output logic                cfg_err,
    input  logic                flush_req,
    output logic                flush_done
);

    state_t             state_q, state_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic               started_q;
    logic               flush_pend_q, flush_pend_d;
    logic               commit_pend_q, commit_pend_d;
    logic               stall, pend, accept, shift_in, drained, swap;

    assign m_valid  = vld_q[LATENCY-1];
    assign m_data   = dp_y;
    assign stall    = m_valid & ~m_ready;
    assign pend     = flush_pend_q | commit_pend_q;
    assign cfg_busy = commit_pend_q;

    // Next-state, handshake and datapath strobes.
    always_comb begin
        state_d       = state_q;
        s_ready       = 1'b0;
        accept        = 1'b0;
        dp_ena        = 1'b0;
        dp_x          = '0;
        shift_in      = 1'b0;
        drained       = 1'b0;
        flush_done    = 1'b0;
        swap          = 1'b0;
        flush_pend_d  = flush_pend_q | flush_req;
        // A commit while one is already pending is ignored by construction.
        commit_pend_d = commit_pend_q | cfg_commit;

        unique case (state_q)
            RUN: begin
                s_ready  = started_q & ~stall & ~pend;
                accept   = s_valid & s_ready;
                dp_x     = s_data;
                // Bubble advance retires a taken result even without a new sample.
                dp_ena   = accept | (m_valid & m_ready);
                shift_in = accept;
                if (pend) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                dp_ena  = ~stall & (vld_q != '0);
                drained = (vld_q == '0) || (dp_ena && (vld_q[LATENCY-2:0] == '0));
                if (drained) begin
                    flush_done   = 1'b1;
                    flush_pend_d = 1'b0;
                    state_d      = commit_pend_q ? SWAP : RUN;
                end
            end
            SWAP: begin
                swap          = 1'b1;
                commit_pend_d = 1'b0;
                state_d       = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        vld_d = dp_ena ? {vld_q[LATENCY-2:0], shift_in} : vld_q;
    end

    // State, slot-valid shift register and pending-request latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            vld_q         <= '0;
            started_q     <= 1'b0;
            flush_pend_q  <= 1'b0;
            commit_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vld_q         <= vld_d;
            started_q     <= 1'b1;
            flush_pend_q  <= flush_pend_d;
            commit_pend_q <= commit_pend_d;
        end
    end

    fir_coef_bank u_coef_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (cfg_wr),
        .addr  (cfg_addr),
        .wdata (cfg_data),
        .swap  (swap),
        .coef  (coef),
        .err   (cfg_err)
    );

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer with a stub datapath and a
// queue-based reference of expected results.
module tb_fir_tap_sequencer;
    import fir_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [XW-1:0]       s_data = '0;
    logic [XW-1:0]       dp_x;
    logic                dp_ena;
    logic [YW-1:0]       dp_y;
    logic                m_valid;
    logic                m_ready = 1'b0;
    logic [YW-1:0]       m_data;
    logic [NTAPS*CW-1:0] coef;
    logic                cfg_wr = 1'b0;
    logic [2:0]          cfg_addr = '0;
    logic [CW-1:0]       cfg_data = '0;
    logic                cfg_commit = 1'b0;
    logic                cfg_busy;
    logic                cfg_err;
    logic                flush_req = 1'b0;
    logic                flush_done;

    int n_vec = 0;
    int n_err = 0;
    int n_fdone = 0;

    logic [YW-1:0]       exp_q [$];
    logic [NTAPS*CW-1:0] m_shadow = '0;
    logic [NTAPS*CW-1:0] m_active = '0;
    logic [NTAPS*CW-1:0] m_prev = '0;
    logic                m_err = 1'b0;

    always #5 clk = ~clk;

    fir_tap_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .dp_x       (dp_x),
        .dp_ena     (dp_ena),
        .dp_y       (dp_y),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .coef       (coef),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .cfg_busy   (cfg_busy),
        .cfg_err    (cfg_err),
        .flush_req  (flush_req),
        .flush_done (flush_done)
    );

    // Position-weighted gain so a tap-order error changes the result.
    function automatic int weight(input logic [NTAPS*CW-1:0] c);
        int w = 0;
        for (int k = 0; k < int'(NTAPS); k++) begin
            w += (k + 1) * int'($signed(c[k*CW +: CW]));
        end
        return w;
    endfunction

    // Stub datapath: LATENCY-deep delay line; gain applied at the output with the
    // coefficients live at that moment, so an early swap corrupts in-flight results.
    logic [XW-1:0] line_q [LATENCY];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LATENCY); i++) line_q[i] <= '0;
        end else if (dp_ena) begin
            for (int i = int'(LATENCY) - 1; i > 0; i--) line_q[i] <= line_q[i-1];
            line_q[0] <= dp_x;
        end
    end
    assign dp_y = YW'(int'($signed(line_q[LATENCY-1])) * weight(coef));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Reference model: every accepted sample yields one result, in order, scaled by
    // the coefficient set committed before it was accepted.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_shadow = '0;
            m_active = '0;
            m_prev   = '0;
            m_err    = 1'b0;
        end else begin
            if (m_valid && !m_ready) check_eq("stall_ena", dp_ena, 1'b0);
            if (dp_ena && !m_valid && !(s_valid && s_ready)) check_eq("flush_x", dp_x, '0);
            if (!cfg_busy) check_eq("coef", coef, m_active);
            else check_eq("coef_hold", coef, m_prev);
            check_eq("cfg_err", cfg_err, m_err);
            if (flush_done) n_fdone++;
            if (m_valid && m_ready) begin
                check_eq("out_pending", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check_eq("m_data", m_data, exp_q.pop_front());
            end
            if (s_valid && s_ready) exp_q.push_back(YW'(int'($signed(s_data)) * weight(m_active)));
            if (cfg_wr) begin
                if (cfg_addr < 3'(NTAPS)) m_shadow[cfg_addr*CW +: CW] = cfg_data;
                else m_err = 1'b1;
            end
            if (cfg_commit && !cfg_busy) begin
                m_prev   = m_active;
                m_active = m_shadow;
            end
        end
    end

    task automatic write_coef(input logic [2:0] a, input logic [CW-1:0] d);
        cfg_wr = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic commit_wait();
        int n = 0;
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        while (cfg_busy && n < 60) begin
            step();
            n++;
        end
        check_eq("commit_done", cfg_busy, 1'b0);
    endtask

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        for (int i = 0; i < 40; i++) step();
        check_eq("drain_empty", exp_q.size(), 0);
        check_eq("drain_mvalid", m_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, acc, first_mv, mv_run, res, fd, n, rises;
        logic prev_busy;
        logic [YW-1:0] held;

        // Reset state, including the one-cycle s_ready hold-off.
        #26 rst_n = 1'b1;
        settle();
        check_eq("rst_sready", s_ready, 1'b0);
        check_eq("rst_mvalid", m_valid, 1'b0);
        check_eq("rst_ena", dp_ena, 1'b0);
        check_eq("rst_coef", coef, '0);
        check_eq("rst_busy", cfg_busy, 1'b0);
        check_eq("rst_fdone", flush_done, 1'b0);
        step();
        settle();
        check_eq("run_sready", s_ready, 1'b1);
        step();

        // Commit 1,0,0,0,0 into an empty pipe: one flush_done, then swap.
        m_ready = 1'b1;
        write_coef(3'd0, 8'd1);
        f0 = n_fdone;
        commit_wait();
        check_eq("coef_unit", coef, 40'h00_00_00_00_01);
        check_eq("empty_flush_done", n_fdone - f0, 1);

        // Ten back-to-back samples.
        acc = 0; first_mv = -1; mv_run = 0;
        s_valid = 1'b1;
        s_data = 16'($urandom);
        for (int c = 0; c < 40; c++) begin
            settle();
            if (m_valid) begin
                if (first_mv < 0) first_mv = c;
                mv_run++;
            end
            if (s_valid && s_ready) acc++;
            step();
            if (acc == 10) s_valid = 1'b0;
            s_data = 16'($urandom);
        end
        check_eq("first_valid_cycle", first_mv, 5);
        check_eq("valid_run", mv_run, 10);

        // Fill the pipe, then stall the output for 7 cycles.
        m_ready = 1'b0;
        s_valid = 1'b1;
        n = 0;
        while (!m_valid && n < 20) begin
            step();
            s_data = 16'($urandom);
            n++;
        end
        check_eq("fill_mvalid", m_valid, 1'b1);
        held = m_data;
        for (int i = 0; i < 7; i++) begin
            settle();
            check_eq("stall_ena7", dp_ena, 1'b0);
            check_eq("stall_sready", s_ready, 1'b0);
            check_eq("stall_hold", m_data, held);
            step();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check_eq("stall_drained", exp_q.size(), 0);

        // Three samples in flight, then flush.
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = 16'($urandom);
            step();
        end
        s_valid = 1'b0;
        s_data = 16'h7abc;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        res = 0; fd = 0;
        for (int i = 0; i < 15; i++) begin
            settle();
            if (m_valid && m_ready) res++;
            if (flush_done) fd++;
            step();
        end
        check_eq("flush_results", res, 3);
        check_eq("flush_pulses", fd, 1);
        check_eq("flush_empty", m_valid, 1'b0);

        // Rewrite shadow to 2,2,2,2,2 while streaming, then commit.
        s_valid = 1'b1;
        for (int i = 0; i < int'(NTAPS); i++) begin
            s_data = 16'($urandom);
            write_coef(3'(i), 8'd2);
        end
        s_data = 16'($urandom);
        f0 = n_fdone;
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        check_eq("busy_set", cfg_busy, 1'b1);
        n = 0;
        while (cfg_busy && n < 60) begin
            settle();
            check_eq("busy_sready", s_ready, 1'b0);
            step();
            s_data = 16'($urandom);
            n++;
        end
        check_eq("busy_clear", cfg_busy, 1'b0);
        check_eq("coef_two", coef, 40'h02_02_02_02_02);
        check_eq("swap_flush_done", n_fdone - f0, 1);
        settle();
        check_eq("resume_sready", s_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            s_data = 16'($urandom);
        end
        drain();

        // Out-of-range write is dropped and sticky; double commit gives one swap.
        write_coef(3'd6, 8'h55);
        settle();
        check_eq("err_set", cfg_err, 1'b1);
        step();
        write_coef(3'd1, 8'd3);
        settle();
        check_eq("err_sticky", cfg_err, 1'b1);
        step();
        commit_wait();
        check_eq("coef_after_err", coef, 40'h02_02_02_03_02);
        rises = 0;
        prev_busy = 1'b0;
        for (int i = 0; i < 14; i++) begin
            cfg_commit = (i == 0 || i == 2);
            settle();
            if (cfg_busy && !prev_busy) rises++;
            prev_busy = cfg_busy;
            step();
        end
        cfg_commit = 1'b0;
        check_eq("single_swap", rises, 1);

        // Asynchronous reset in the middle of a flush.
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = 16'($urandom);
            step();
        end
        s_valid = 1'b0;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_mvalid", m_valid, 1'b0);
        check_eq("arst_ena", dp_ena, 1'b0);
        check_eq("arst_coef", coef, '0);
        check_eq("arst_err", cfg_err, 1'b0);
        check_eq("arst_busy", cfg_busy, 1'b0);
        step();
        rst_n = 1'b1;
        settle();
        check_eq("arst_sready0", s_ready, 1'b0);
        step();
        settle();
        check_eq("arst_run", s_ready, 1'b1);
        step();

        // Randomized traffic with occasional writes, commits and flushes.
        for (int i = 0; i < 600; i++) begin
            s_valid   = ($urandom_range(0, 3) != 0);
            s_data    = 16'($urandom);
            m_ready   = ($urandom_range(0, 3) != 0);
            flush_req = ($urandom_range(0, 60) == 0);
            cfg_wr    = !cfg_busy && ($urandom_range(0, 15) == 0);
            cfg_addr  = 3'($urandom_range(0, 7));
            cfg_data  = 8'($urandom);
            cfg_commit = !cfg_busy && ($urandom_range(0, 60) == 0);
            step();
        end
        cfg_wr = 1'b0;
        cfg_commit = 1'b0;
        drain();
        check_eq("final_busy", cfg_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
Controller for the five-tap FIR datapath. It converts a valid/ready sample stream into the datapath's `ena` strobe and tracks which pipeline slots hold real samples. It presents a valid/ready result stream at the datapath's y output. It also owns the coefficient registers: double-buffered, with drain-and-swap commits so that no output ever mixes old and new taps.

Parameters:
NTAPS, 5, number of taps and coefficient registers driven
LATENCY, 5, datapath `ena` advances from x accepted to the matching y at the chain output
XW, 16, sample width
YW, 32, accumulator/result width
CW, 8, coefficient width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
s_valid  in  1  input sample valid
s_ready  out  1  input sample accepted when s_valid & s_ready
s_data  in  XW  input sample, signed
dp_x  out  XW  to datapath x_in; s_data in RUN, zero in FLUSH
dp_ena  out  1  datapath advance strobe
dp_y  in  YW  from datapath y_out
m_valid  out  1  result valid
m_ready  in  1  downstream accepts result
m_data  out  YW  result; equals dp_y
coef  out  NTAPS*CW  active coefficients; tap k at bits [k*CW +: CW]
cfg_wr  in  1  shadow write strobe
cfg_addr  in  3  shadow index
cfg_data  in  CW  shadow write data
cfg_commit  in  1  request shadow-to-active swap
cfg_busy  out  1  commit pending or in progress
cfg_err  out  1  sticky: write with cfg_addr >= NTAPS
flush_req  in  1  drain pipeline with zero samples
flush_done  out  1  one-cycle pulse at end of any flush

Behaviour:
- Reset: state=RUN, vld_sr=0, active=0, shadow=0, s_ready=0 for the first cycle after deassert, dp_ena=0, m_valid=0, cfg_busy=0, cfg_err=0, flush_done=0.
- vld_sr: LATENCY-bit shift register, shifted only when dp_ena=1.
  - Shift-in bit: 1 for an accepted sample in RUN, 0 in FLUSH.
  - m_valid = vld_sr[LATENCY-1].
- stall = m_valid & ~m_ready. dp_ena never asserts while stall=1, so the datapath and dp_y hold.
- RUN:
  - s_ready = ~stall & ~pend.
  - dp_ena = s_valid & s_ready.
  - A result with m_ready=1 and no new sample: dp_ena pulses with shift-in 0 to retire it (bubble advance).
- pend = flush_req latched or cfg_commit latched. When set, RUN stops accepting and moves to FLUSH next cycle.
- FLUSH:
  - dp_x=0; dp_ena=~stall.
  - Exits when vld_sr==0 after the shift; at most LATENCY non-stalled cycles.
  - If vld_sr==0 on entry: one cycle, no ena.
  - On exit: flush_done pulses. Next state is SWAP if a commit is pending, else RUN.
- SWAP (1 cycle): active<=shadow; cfg_busy clears the following cycle; returns to RUN.
- cfg_busy = commit latched through end of SWAP.
  - cfg_commit while busy: ignored.
  - cfg_wr while busy: allowed, updates shadow only.
  - A write in the same cycle as SWAP lands in shadow after the copy.
- cfg_err: sets on cfg_wr with cfg_addr >= NTAPS; the write is dropped; cleared only by reset.
- Simultaneous flush_req and cfg_commit: single FLUSH, then SWAP, one flush_done.
- Reset mid-FLUSH or mid-SWAP: all state returns to reset values; the commit is lost.
- Datapath y_in is tied to zero at integration; the sequencer does not drive it.

Decomposition:
- Shared package fir_pkg: NTAPS, XW, YW, CW, LATENCY constants; state enum {RUN, FLUSH, SWAP}.
- One sub-module, fir_coef_bank: shadow and active registers, write decode, cfg_err, swap.
- The sequencer FSM and vld_sr stay in the top.

Test Plan:
- Reset then 10 back-to-back samples, m_ready=1, coef preset 1,0,0,0,0 → m_valid first rises 5 accepted cycles after the first sample, then stays high for 10 cycles; no gaps.
- Fill the pipe, hold m_ready=0 for 7 cycles → dp_ena=0, s_ready=0, m_data stable for all 7 cycles; no result lost or duplicated after release.
- 3 samples in flight, pulse flush_req → dp_x=0 during FLUSH; exactly 3 results emitted; flush_done pulses once; vld_sr=0.
- Write shadow 2,2,2,2,2 while streaming, then cfg_commit → s_ready low until swap; coef changes only after the last old-coefficient result leaves; cfg_busy falls one cycle after SWAP.
- cfg_wr addr=6 → cfg_err=1 and sticky; shadow unchanged. cfg_commit pulsed twice while busy → only one SWAP.
- rst_n asserted mid-FLUSH (asynchronous, between edges) → m_valid, dp_ena and coef zero immediately; RUN after release.
